// File: rtl/fifo72_pkg.sv
// Shared definitions for the 72-bit ADC capture FIFO: word width, default depth and word type.
package fifo72_pkg;

    localparam int DATA_W        = 72;
    localparam int DEFAULT_DEPTH = 512;

    // {sync[3:0], outofrange[3:0], data[63:0]}
    typedef logic [DATA_W-1:0] fifo72_word_t;

endpackage

// File: rtl/fifo72_ram.sv
// Simple dual-port storage for the FIFO: one write port, one registered read port with enable.
// The read register doubles as the FIFO's dout and is cleared by reset or clr; the array is never cleared.
module fifo72_ram
    import fifo72_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  fifo72_word_t      wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output fifo72_word_t      rd_data
);

    fifo72_word_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register holds its value unless a read is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_72.sv
// Single-clock 72-bit FIFO with standard (registered, non-fall-through) read and occupancy flags.
// Optional data_count output is enabled by defining SYNC_FIFO_72_DATA_COUNT_EN.
module sync_fifo_72
    import fifo72_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int AE_LEVEL = 1,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  fifo72_word_t din,
    input  logic         wr_en,
    input  logic         rd_en,
    output fifo72_word_t dout,
    output logic         empty,
    output logic         almost_empty,
    output logic         almost_full,
    output logic         full
`ifdef SYNC_FIFO_72_DATA_COUNT_EN
    ,
    output logic [ADDR_W:0] data_count
`endif
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AE_CNT   = (ADDR_W + 1)'(AE_LEVEL);
    localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W + 1)'(AF_LEVEL);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              wr_acc;
    logic              rd_acc;

    // A request is taken on a rising edge when its enable is high and the FIFO
    // can serve it (write: not full, read: not empty); otherwise it is dropped
    // with no side effects. clr overrides both requests.
    assign wr_acc = wr_en & ~full  & ~clr;
    assign rd_acc = rd_en & ~empty & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign empty        = (count == '0);
    assign almost_empty = (count <= AE_CNT);
    assign almost_full  = (count >= AF_CNT);
    assign full         = (count == FULL_CNT);

`ifdef SYNC_FIFO_72_DATA_COUNT_EN
    assign data_count = count;
`else
    // count stays internal; it only feeds the flag decode.
`endif

    // Full and empty are exclusive, so a same-cycle read and write never share an address.
    fifo72_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (din),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (dout)
    );

endmodule

// File: tb/tb_sync_fifo_72.sv
// Randomized self-checking bench for sync_fifo_72 against a queue-based reference model.
module tb_sync_fifo_72;
    import fifo72_pkg::*;

    localparam int DEPTH  = DEFAULT_DEPTH;
    localparam int ADDR_W = $clog2(DEPTH);

    logic         clk;
    logic         rst_n;
    logic         clr;
    fifo72_word_t din;
    logic         wr_en;
    logic         rd_en;
    fifo72_word_t dout;
    logic         empty;
    logic         almost_empty;
    logic         almost_full;
    logic         full;
`ifdef SYNC_FIFO_72_DATA_COUNT_EN
    logic [ADDR_W:0] data_count;
`endif

    int checks   = 0;
    int failures = 0;

    fifo72_word_t model_q[$];
    fifo72_word_t model_dout;

    sync_fifo_72 #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .din          (din),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .dout         (dout),
        .empty        (empty),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .full         (full)
`ifdef SYNC_FIFO_72_DATA_COUNT_EN
        ,
        .data_count   (data_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = model_q.size();
        check({tag, ".dout"},         dout,         model_dout);
        check({tag, ".empty"},        empty,        72'(n == 0));
        check({tag, ".almost_empty"}, almost_empty, 72'(n <= 1));
        check({tag, ".almost_full"},  almost_full,  72'(n >= DEPTH - 1));
        check({tag, ".full"},         full,         72'(n == DEPTH));
`ifdef SYNC_FIFO_72_DATA_COUNT_EN
        check({tag, ".data_count"},   data_count,   72'(n));
`endif
    endtask

    function automatic fifo72_word_t rand_word();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[71:0];
    endfunction

    // One clock: drive inputs, let the DUT take the edge, update the model from the
    // FIFO rules, then compare on the falling edge.
    task automatic step(input string tag, input logic w, input logic r, input logic c,
                        input fifo72_word_t d);
        bit can_w, can_r;
        wr_en = w; rd_en = r; clr = c; din = d;
        @(posedge clk);
        if (c) begin
            model_q.delete();
            model_dout = '0;
        end else begin
            can_r = r && (model_q.size() > 0);
            can_w = w && (model_q.size() < DEPTH);
            if (can_r) model_dout = model_q.pop_front();
            if (can_w) model_q.push_back(d);
        end
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
        check_all(tag);
    endtask

    task automatic fill_to(input string tag, input int n);
        while (model_q.size() < n) step(tag, 1'b1, 1'b0, 1'b0, rand_word());
    endtask

    task automatic drain(input string tag);
        while (model_q.size() > 0) step(tag, 1'b0, 1'b1, 1'b0, '0);
    endtask

    initial begin
        int writes;
        int lvl;
        logic w, r, c;

        rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        model_dout = '0;
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        @(negedge clk);
        step("underflow", 1'b0, 1'b1, 1'b0, '0);
        check("underflow.dout_zero", dout, 72'h0);

        // Basic ordering with fixed words.
        step("basic_wr", 1'b1, 1'b0, 1'b0, 72'h1);
        step("basic_wr", 1'b1, 1'b0, 1'b0, 72'h2);
        step("basic_wr", 1'b1, 1'b0, 1'b0, 72'h3);
        step("basic_rd", 1'b0, 1'b1, 1'b0, '0);
        check("basic_rd1", dout, 72'h1);
        step("basic_rd", 1'b0, 1'b1, 1'b0, '0);
        check("basic_rd2", dout, 72'h2);
        step("basic_rd", 1'b0, 1'b1, 1'b0, '0);
        check("basic_rd3", dout, 72'h3);
        check("basic_empty", empty, 1'b1);

        // Fill to capacity, then overflow with DEAD.
        fill_to("fill", DEPTH);
        check("fill_full", full, 1'b1);
        step("overflow", 1'b1, 1'b0, 1'b0, 72'hDEAD);
        while (model_q.size() > 0) begin
            step("fill_drain", 1'b0, 1'b1, 1'b0, '0);
            check("fill_no_dead", 72'(dout == 72'hDEAD), 72'h0);
        end

        // Simultaneous ops at empty and at full.
        step("simul_empty", 1'b1, 1'b1, 1'b0, 72'hA5);
        step("simul_empty_rd", 1'b0, 1'b1, 1'b0, '0);
        check("simul_empty_word", dout, 72'hA5);
        fill_to("simul_fill", DEPTH);
        step("simul_full", 1'b1, 1'b1, 1'b0, 72'hBEEF);
        check("simul_full_count", 72'(full), 72'h0);
        drain("simul_drain");

        // Streaming with fill level held between 2 and 10 so pointers wrap repeatedly.
        fill_to("wrap_prime", 2);
        writes = 0;
        while (writes < 3 * DEPTH) begin
            lvl = model_q.size();
            w = (lvl < 10) && ($urandom_range(0, 3) != 0);
            r = (lvl > 2)  && ($urandom_range(0, 3) != 0);
            if (w) writes++;
            step("wrap", w, r, 1'b0, rand_word());
        end
        drain("wrap_drain");

        // Unconstrained random traffic with rare clr pulses.
        repeat (600) begin
            w = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 150) == 0);
            step("random", w, r, c, rand_word());
        end

        // clr with 100 words stored, asserted together with requests.
        drain("pre_clr");
        fill_to("clr_fill", 100);
        step("clr_rd", 1'b0, 1'b1, 1'b0, '0);
        step("clr", 1'b1, 1'b1, 1'b1, rand_word());
        check("clr_empty", empty, 1'b1);
        step("post_clr_wr", 1'b1, 1'b0, 1'b0, 72'h77);
        step("post_clr_rd", 1'b0, 1'b1, 1'b0, '0);
        check("post_clr_word", dout, 72'h77);

        // Asynchronous reset with 100 words stored, checked before any clock edge.
        fill_to("rst_fill", 100);
        step("rst_rd", 1'b0, 1'b1, 1'b0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        model_dout = '0;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("post_rst");
        step("post_rst_wr", 1'b1, 1'b0, 1'b0, 72'h99);
        step("post_rst_rd", 1'b0, 1'b1, 1'b0, '0);
        check("post_rst_word", dout, 72'h99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
